// File: rtl/send_ctrl_pkg.sv
// rtl/send_ctrl_pkg.sv - shared types and constants for the send job scheduler
package send_ctrl_pkg;

  localparam int LEN_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_EARLY   = 2'b10;

endpackage

// File: rtl/send_job_fifo.sv
// rtl/send_job_fifo.sv - first-word fall-through descriptor queue with flush
module send_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot a simultaneous push needs, so a full FIFO still accepts one.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/send_job_ctrl.sv
// rtl/send_job_ctrl.sv - queues send descriptors, gates the upstream stream, tracks completion
module send_job_ctrl
  import send_ctrl_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 1048576
) (
  input  logic             s_axis_aclk,
  input  logic             s_axis_aresetn,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             abort,
  output logic [LEN_W-1:0] send_len,
  input  logic [31:0]      data_cnt,
  input  logic             write_hsked,
  input  logic             tx_done,
  output logic             stream_en,
  output logic             busy,
  output logic             done_pulse,
  output logic [15:0]      done_cnt,
  output logic [31:0]      last_cnt,
  output logic [1:0]       err_code
);

  localparam int WD_W = $clog2(TIMEOUT);

  state_t           state;
  state_t           next_state;
  logic [1:0]       err_next;
  logic [LEN_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             run_ok;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] beat_inc;
  logic [WD_W-1:0]  wd_cnt;
  logic             wd_expired;
  logic             wd_clear;
  logic             last_beat;

  // run_ok is a registered "not in ERR" flag that also holds job_ready low during reset.
  assign job_ready  = ~fifo_full & ~abort & run_ok;
  assign push       = job_valid & job_ready;
  assign pop        = (state == IDLE) & ~fifo_empty & ~abort;
  assign beat_inc   = beat_cnt + 1'b1;
  assign last_beat  = write_hsked & (beat_inc == send_len);
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
  assign wd_clear   = tx_done | ((state == RUN) & write_hsked);

  send_job_fifo #(.DEPTH(QDEPTH), .W(LEN_W)) u_fifo (
    .clk   (s_axis_aclk),
    .rst_n (s_axis_aresetn),
    .flush (abort),
    .push  (push),
    .din   (job_len),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    next_state = state;
    err_next   = err_code;
    case (state)
      IDLE:  if (!fifo_empty) next_state = LOAD;
      LOAD:  next_state = (send_len == '0) ? DONE : RUN;
      RUN: begin
        if (last_beat) begin
          next_state = tx_done ? DONE : DRAIN;
        end else if (tx_done) begin
          next_state = ERR;
          err_next   = ERR_EARLY;
        end else if (wd_expired && !write_hsked) begin
          next_state = ERR;
          err_next   = ERR_TIMEOUT;
        end
      end
      DRAIN: begin
        if (tx_done) begin
          next_state = DONE;
        end else if (wd_expired) begin
          next_state = ERR;
          err_next   = ERR_TIMEOUT;
        end
      end
      DONE:    next_state = IDLE;
      ERR:     next_state = ERR;
      default: next_state = IDLE;
    endcase
    if (abort) begin
      next_state = IDLE;
      err_next   = ERR_NONE;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state      <= IDLE;
      err_code   <= ERR_NONE;
      stream_en  <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      run_ok     <= 1'b0;
      send_len   <= '0;
      beat_cnt   <= '0;
      wd_cnt     <= '0;
      done_cnt   <= '0;
      last_cnt   <= '0;
    end else begin
      state      <= next_state;
      err_code   <= err_next;
      stream_en  <= (next_state == RUN);
      // A pop always moves to LOAD, so a non-empty queue here still means work pending.
      busy       <= ~abort & ((next_state != IDLE) | push | ~fifo_empty);
      done_pulse <= (next_state == DONE);
      run_ok     <= (next_state != ERR);
      if (pop) begin
        send_len <= fifo_dout;
        beat_cnt <= '0;
        wd_cnt   <= '0;
      end else if (state == RUN || state == DRAIN) begin
        if (state == RUN && write_hsked) beat_cnt <= beat_inc;
        wd_cnt <= wd_clear ? '0 : wd_cnt + 1'b1;
      end
      if (state == DONE && !abort) begin
        done_cnt <= done_cnt + 1'b1;
        last_cnt <= data_cnt;
      end
    end
  end

endmodule
